// File: rtl/mac_engine.sv
// mac_engine: signed multiply-accumulate responder for the start_mac/mac_done
// handshake. Consumes VEC_LEN data/weight pairs and publishes a saturated sum.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   start_mac    in   begin an operation (honoured only in IDLE)
//   shift_enable in   operand-valid strobe, sampled in ACCUM
//   data_in      in   [DATA_W-1:0] signed data operand (FIFO)
//   weight_in    in   [DATA_W-1:0] signed weight operand (IMEM)
//   busy         out  high in ACCUM and DRAIN
//   mac_done     out  registered one-cycle completion pulse
//   acc_out      out  [ACC_W-1:0] last completed signed result
//   overflow     out  sticky saturation flag for current/last operation

module mac_engine #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int VEC_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mac,
    input  logic              shift_enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] weight_in,
    output logic              busy,
    output logic              mac_done,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(VEC_LEN + 1);
    localparam int EXT_W  = ACC_W + 1 - PROD_W;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              pvalid_q, pvalid_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic              accept;
    logic              take_pair;
    logic              last_pair;
    logic [PROD_W-1:0] mult;
    logic [ACC_W:0]    sum;
    logic              sum_ovf;
    logic [ACC_W-1:0]  sum_sat;

    assign accept    = (state_q == IDLE) && start_mac;
    assign take_pair = (state_q == ACCUM) && shift_enable;
    assign last_pair = take_pair && (count_q == LAST);

    assign mult = PROD_W'($signed(data_in) * $signed(weight_in));

    // One extra bit is enough: a single product fits in ACC_W, so the
    // sum of an in-range accumulator and a product can only spill by one bit.
    assign sum = {acc_q[ACC_W-1], acc_q}
               + {{EXT_W{prod_q[PROD_W-1]}}, prod_q};

    assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        sum_sat = sum[ACC_W-1:0];
        if (sum_ovf) begin
            sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_mac) state_d = ACCUM;
            ACCUM: if (last_pair) state_d = DRAIN;
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == ACCUM) || (state_q == DRAIN);
    end

    // Datapath next-state
    always_comb begin
        count_d   = count_q;
        prod_d    = prod_q;
        pvalid_d  = 1'b0;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        if (take_pair) begin
            prod_d   = mult;
            pvalid_d = 1'b1;
            count_d  = count_q + 1'b1;
        end

        // Accumulate stage runs one cycle behind sampling, so a fresh pair
        // can be taken on the same edge the previous product is summed.
        if (pvalid_q) begin
            acc_d = sum_sat;
            if (sum_ovf) begin
                ovf_d = 1'b1;
            end
        end

        if (state_q == DRAIN) begin
            acc_out_d = pvalid_q ? sum_sat : acc_q;
            done_d    = 1'b1;
        end

        if (accept) begin
            count_d  = '0;
            acc_d    = '0;
            ovf_d    = 1'b0;
            pvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            prod_q    <= '0;
            pvalid_q  <= 1'b0;
            acc_q     <= '0;
            acc_out_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            prod_q    <= prod_d;
            pvalid_q  <= pvalid_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign mac_done = done_q;
    assign acc_out  = acc_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_engine.sv
// tb_mac_engine: directed self-checking bench for mac_engine
// (DATA_W=8, ACC_W=16, VEC_LEN=4).

module tb_mac_engine;

    logic        clk;
    logic        reset;
    logic        start_mac;
    logic        shift_enable;
    logic [7:0]  data_in;
    logic [7:0]  weight_in;
    logic        busy;
    logic        mac_done;
    logic [15:0] acc_out;
    logic        overflow;

    int n_cmp;
    int n_bad;
    int done_pulses;

    logic [7:0] da [4];
    logic [7:0] wa [4];

    mac_engine #(
        .DATA_W (8),
        .ACC_W  (16),
        .VEC_LEN(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_mac   (start_mac),
        .shift_enable(shift_enable),
        .data_in     (data_in),
        .weight_in   (weight_in),
        .busy        (busy),
        .mac_done    (mac_done),
        .acc_out     (acc_out),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mac_done) done_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pairs(input int d0, input int w0,
                             input int d1, input int w1,
                             input int d2, input int w2,
                             input int d3, input int w3);
        da[0] = 8'(d0); wa[0] = 8'(w0);
        da[1] = 8'(d1); wa[1] = 8'(w1);
        da[2] = 8'(d2); wa[2] = 8'(w2);
        da[3] = 8'(d3); wa[3] = 8'(w3);
    endtask

    // Drives start plus four pairs; returns #1 after the last-pair edge.
    task automatic do_op(input int bub, input bit junk_start,
                         input bit mid_start);
        start_mac    = 1'b1;
        shift_enable = junk_start;
        data_in      = 8'd50;
        weight_in    = 8'd50;
        tick();
        start_mac = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int b = 0; b < bub; b++) begin
                    shift_enable = 1'b0;
                    data_in      = 8'd100;
                    weight_in    = 8'd100;
                    tick();
                end
            end
            shift_enable = 1'b1;
            data_in      = da[i];
            weight_in    = wa[i];
            start_mac    = mid_start && (i == 1);
            tick();
            start_mac = 1'b0;
        end
        shift_enable = 1'b0;
        data_in      = 8'd0;
        weight_in    = 8'd0;
    endtask

    task automatic check_done(input string nm, input logic [15:0] exp_acc,
                              input logic exp_ovf);
        // At E: still draining
        n_cmp++;
        if (mac_done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s at E: mac_done=%b busy=%b, want 0/1",
                     nm, mac_done, busy);
        end
        tick();
        n_cmp++;
        if (mac_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s at E+1: mac_done=%b busy=%b, want 1/0",
                     nm, mac_done, busy);
        end
        n_cmp++;
        if (acc_out !== exp_acc) begin
            n_bad++;
            $display("FAIL %s acc_out: got %0d want %0d", nm,
                     $signed(acc_out), $signed(exp_acc));
        end
        n_cmp++;
        if (overflow !== exp_ovf) begin
            n_bad++;
            $display("FAIL %s overflow: got %b want %b", nm, overflow,
                     exp_ovf);
        end
        tick();
        n_cmp++;
        if (mac_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s at E+2: mac_done=%b busy=%b, want 0/0",
                     nm, mac_done, busy);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        start_mac    = 1'($urandom);
        shift_enable = 1'($urandom);
        data_in      = 8'($urandom);
        weight_in    = 8'($urandom);
        tick();
        tick();
        n_cmp++;
        if ({busy, mac_done, overflow} !== 3'b000 || acc_out !== 16'd0) begin
            n_bad++;
            $display("FAIL reset: busy=%b done=%b ovf=%b acc=%0d, want 0",
                     busy, mac_done, overflow, acc_out);
        end
        start_mac    = 1'b0;
        shift_enable = 1'b0;
        reset        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({busy, mac_done, overflow} !== 3'b000 ||
                acc_out !== 16'd0) begin
                n_bad++;
                $display("FAIL idle_hold cyc %0d: busy=%b done=%b acc=%0d",
                         i, busy, mac_done, acc_out);
            end
        end
    endtask

    task automatic test_basic();
        set_pairs(3, 2, -4, 5, 7, 7, 1, -1);
        done_pulses = 0;
        do_op(0, 1'b0, 1'b0);
        check_done("basic", 16'd34, 1'b0);
        n_cmp++;
        if (done_pulses !== 1) begin
            n_bad++;
            $display("FAIL basic pulses: got %0d want 1", done_pulses);
        end
    endtask

    task automatic test_bubbles();
        set_pairs(3, 2, -4, 5, 7, 7, 1, -1);
        done_pulses = 0;
        do_op(2, 1'b0, 1'b0);
        check_done("bubbles", 16'd34, 1'b0);
        n_cmp++;
        if (done_pulses !== 1) begin
            n_bad++;
            $display("FAIL bubbles pulses: got %0d want 1", done_pulses);
        end
    endtask

    task automatic test_saturation();
        set_pairs(127, 127, 127, 127, 127, 127, 127, 127);
        do_op(0, 1'b0, 1'b0);
        check_done("sat_pos", 16'h7FFF, 1'b1);
        set_pairs(-128, 127, -128, 127, -128, 127, -128, 127);
        do_op(0, 1'b0, 1'b0);
        check_done("sat_neg", 16'h8000, 1'b1);
        // Clamp at 32767 then -16256 -> 16511, flag stays set
        set_pairs(127, 127, 127, 127, 127, 127, -128, 127);
        do_op(0, 1'b0, 1'b0);
        check_done("sat_cont", 16'd16511, 1'b1);
        set_pairs(1, 1, 1, 1, 1, 1, 1, 1);
        start_mac = 1'b1;
        tick();
        start_mac = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            shift_enable = 1'b1;
            data_in      = da[i];
            weight_in    = wa[i];
            tick();
        end
        shift_enable = 1'b0;
        check_done("sat_recover", 16'd4, 1'b0);
    endtask

    task automatic test_ignored();
        set_pairs(3, 2, -4, 5, 7, 7, 1, -1);
        done_pulses = 0;
        do_op(0, 1'b1, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ign E busy: got %b want 1", busy);
        end
        tick();
        start_mac = 1'b1;
        n_cmp++;
        if (acc_out !== 16'd34 || mac_done !== 1'b1) begin
            n_bad++;
            $display("FAIL ign result: acc=%0d done=%b want 34/1",
                     $signed(acc_out), mac_done);
        end
        tick();
        start_mac = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done_pulses !== 1) begin
            n_bad++;
            $display("FAIL ign done_start: busy=%b pulses=%0d want 0/1",
                     busy, done_pulses);
        end
        for (int i = 0; i < 5; i++) begin
            shift_enable = 1'b1;
            data_in      = 8'd9;
            weight_in    = 8'd9;
            tick();
        end
        shift_enable = 1'b0;
        n_cmp++;
        if (acc_out !== 16'd34 || busy !== 1'b0 || done_pulses !== 1) begin
            n_bad++;
            $display("FAIL ign idle_shift: acc=%0d busy=%b pulses=%0d",
                     $signed(acc_out), busy, done_pulses);
        end
    endtask

    task automatic test_reset_mid();
        start_mac = 1'b1;
        tick();
        start_mac = 1'b0;
        for (int i = 0; i < 2; i++) begin
            shift_enable = 1'b1;
            data_in      = 8'd5;
            weight_in    = 8'd5;
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || acc_out !== 16'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b acc=%0d ovf=%b want 0",
                     busy, $signed(acc_out), overflow);
        end
        shift_enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        set_pairs(2, 3, 2, 3, 2, 3, 2, 3);
        done_pulses = 0;
        do_op(0, 1'b0, 1'b0);
        check_done("after_reset", 16'd24, 1'b0);
        tick();
        n_cmp++;
        if (done_pulses !== 1) begin
            n_bad++;
            $display("FAIL after_reset pulses: got %0d want 1", done_pulses);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        done_pulses  = 0;
        reset        = 1'b1;
        start_mac    = 1'b0;
        shift_enable = 1'b0;
        data_in      = 8'd0;
        weight_in    = 8'd0;
        test_reset();
        test_basic();
        test_bubbles();
        test_saturation();
        test_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_engine.md
Name: mac_engine

Overview:
- Multiply-accumulate responder on the far side of the controller's start_mac/mac_done handshake.
- On start_mac it clears its accumulator, then consumes one signed data/weight pair per cycle in which shift_enable is high.
- Data comes from the FIFO read port; weights come from the shifted IMEM.
- After VEC_LEN pairs it publishes a saturated dot product and pulses mac_done so the controller can advance.

Parameters:
- DATA_W, 8: width of data_in and weight_in, signed two's complement.
- ACC_W, 24: accumulator and result width, signed; must be >= 2*DATA_W.
- VEC_LEN, 16: number of operand pairs per MAC operation; must be >= 1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_mac  in  1  single-cycle request to begin an operation; honoured only in IDLE.
- shift_enable  in  1  operand-valid strobe; data_in/weight_in are sampled when high in ACCUM.
- data_in  in  DATA_W  signed data operand from the FIFO.
- weight_in  in  DATA_W  signed weight operand from the IMEM.
- busy  out  1  high in ACCUM and DRAIN.
- mac_done  out  1  registered one-cycle completion pulse.
- acc_out  out  ACC_W  last completed result, signed.
- overflow  out  1  sticky saturation flag for the current or last operation.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; count, product register, product-valid and accumulator=0.
  - busy=0, mac_done=0, acc_out=0, overflow=0.
  - Takes effect immediately even mid-operation; the partial sum is discarded.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start_mac=1 -> ACCUM; clear accumulator, count and overflow.
  - shift_enable is ignored in IDLE, including the cycle where start_mac is sampled.
- ACCUM:
  - On each edge with shift_enable=1: product register <= signed data_in*weight_in (2*DATA_W bits), product-valid <= 1, count++.
  - When the VEC_LEN-th pair is sampled at edge E -> DRAIN.
  - shift_enable=0 cycles are bubbles: no count change, no pair consumed.
  - start_mac is ignored in ACCUM, DRAIN and DONE.
- Accumulate stage:
  - On each edge where product-valid=1, accumulator <= sat(accumulator + sign-extended product).
  - This overlaps with sampling of the next pair, so the pipeline sustains one pair per cycle.
- DRAIN: at edge E+1 the final product is accumulated -> DONE. acc_out <= final saturated sum, and mac_done is registered high.
- DONE: mac_done=1 for exactly the one cycle between E+1 and E+2; at E+2 -> IDLE, mac_done=0.
- Latency: mac_done rises 1 cycle after the edge sampling the last pair. Minimum start-to-done is VEC_LEN+2 cycles.
- acc_out holds its value until the next completion or reset; it is not cleared by start_mac.
- Saturation:
  - If the true sum exceeds 2^(ACC_W-1)-1 or falls below -2^(ACC_W-1), clamp to that bound and set overflow=1.
  - Once clamped, later in-range additions continue from the clamped value.
  - overflow stays set until the next accepted start_mac or reset.
- VEC_LEN=1: ACCUM -> DRAIN on the first sampled pair; normal DRAIN/DONE sequence.
- busy=1 exactly in ACCUM and DRAIN; 0 in IDLE and DONE.

Test Plan:
- Reset: assert reset with random inputs -> busy=0, mac_done=0, acc_out=0, overflow=0. Deassert with no start_mac -> state stays IDLE, outputs unchanged for 20 cycles.
- Basic dot product (DATA_W=8, VEC_LEN=4): start_mac, then 4 consecutive shift_enable pairs (3,2),(-4,5),(7,7),(1,-1) -> mac_done high for exactly 1 cycle, one cycle after the 4th pair edge; acc_out=34; overflow=0; busy falls with mac_done rising.
- Bubbles: same pairs with shift_enable low for 2 cycles between each pair -> acc_out=34; mac_done timing relative to the last pair unchanged; no extra pairs counted.
- Saturation (ACC_W=16, VEC_LEN=4):
  - Positive: four pairs (127,127) -> acc_out=32767, overflow=1.
  - Negative: next op with four pairs (-128,127) -> acc_out=-32768, overflow=1.
  - Recovery: next op with pairs (1,1) -> overflow cleared on start_mac; acc_out=4, overflow=0.
- Ignored requests: start_mac pulsed mid-ACCUM and during DONE -> count and accumulator unaffected, result unchanged. shift_enable with data in IDLE -> no accumulation; acc_out unchanged.
- Reset mid-operation: reset asserted after 2 of 4 pairs -> immediate IDLE, busy=0, acc_out=0. Then a full new operation with pairs (2,3)x4 -> acc_out=24, mac_done pulses once.
